// File: rtl/sign_extend_unit.sv
// Registered immediate extension: 16-bit field to 32-bit operand.
// One-cycle latency; result selected by a 3-bit extension mode.
module sign_extend_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [2:0]  mode,
    input  logic [15:0] a,
    output logic        out_valid,
    output logic [31:0] saida,
    output logic        mode_err
);

    typedef enum logic [2:0] {
        M_SEXT16 = 3'b000,
        M_ZEXT16 = 3'b001,
        M_LUI    = 3'b010,
        M_BRANCH = 3'b011,
        M_SEXT8  = 3'b100,
        M_ZEXT8  = 3'b101,
        M_SEXT12 = 3'b110,
        M_RSVD   = 3'b111
    } mode_e;

    mode_e       mode_s;
    logic [31:0] saida_d;
    logic        err_d;
    logic        valid_q;
    logic [31:0] saida_q;
    logic        err_q;

    assign mode_s = mode_e'(mode);

    always_comb begin
        saida_d = 32'h0;
        err_d   = 1'b0;
        unique case (mode_s)
            M_SEXT16: saida_d = {{16{a[15]}}, a};
            M_ZEXT16: saida_d = {16'h0, a};
            M_LUI:    saida_d = {a, 16'h0};
            M_BRANCH: saida_d = {{14{a[15]}}, a, 2'b00};
            M_SEXT8:  saida_d = {{24{a[7]}}, a[7:0]};
            M_ZEXT8:  saida_d = {24'h0, a[7:0]};
            M_SEXT12: saida_d = {{20{a[11]}}, a[11:0]};
            M_RSVD:   err_d   = 1'b1;
        endcase
    end

    // Data registers only load on a valid beat so idle X inputs never leak.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            saida_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                saida_q <= saida_d;
                err_q   <= err_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign saida     = saida_q;
    assign mode_err  = err_q;

endmodule

// File: tb/tb_sign_extend_unit.sv
// Bench for sign_extend_unit: arithmetic reference model checked
// every cycle, plus directed literal expectations.
module tb_sign_extend_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [2:0]  mode;
    logic [15:0] a;
    logic        out_valid;
    logic [31:0] saida;
    logic        mode_err;

    int checks;
    int failures;

    logic        armed;
    logic        m_v;
    logic [31:0] m_s;
    logic        m_e;

    sign_extend_unit dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .mode     (mode),
        .a        (a),
        .out_valid(out_valid),
        .saida    (saida),
        .mode_err (mode_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference built from integer arithmetic rather than bit slicing.
    function automatic logic [32:0] model(input logic [2:0] m,
                                          input logic [15:0] x);
        int v;
        int lo;
        logic e;
        e = 1'b0;
        v = 0;
        case (m)
            3'd0: v = int'($signed(x));
            3'd1: v = int'(x);
            3'd2: v = int'(x) * 65536;
            3'd3: v = int'($signed(x)) * 4;
            3'd4: begin
                lo = int'(x) % 256;
                v = (lo >= 128) ? lo - 256 : lo;
            end
            3'd5: v = int'(x) % 256;
            3'd6: begin
                lo = int'(x) % 4096;
                v = (lo >= 2048) ? lo - 4096 : lo;
            end
            default: begin
                v = 0;
                e = 1'b1;
            end
        endcase
        return {e, 32'(v)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            armed <= 1'b1;
            m_v   <= 1'b0;
            m_s   <= 32'h0;
            m_e   <= 1'b0;
        end else if (in_valid === 1'b1) begin
            m_v        <= 1'b1;
            {m_e, m_s} <= model(mode, a);
        end else begin
            m_v <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (armed === 1'b1) begin
            chk("model_valid", 32'(out_valid), 32'(m_v));
            chk("model_saida", saida, m_s);
            chk("model_err", 32'(mode_err), 32'(m_e));
        end
    end

    task automatic step(input logic v, input logic [2:0] m,
                        input logic [15:0] x);
        in_valid = v;
        mode     = m;
        a        = x;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit(input string nm, input logic [31:0] s,
                       input logic v, input logic e);
        chk({nm, "_saida"}, saida, s);
        chk({nm, "_valid"}, 32'(out_valid), 32'(v));
        chk({nm, "_err"}, 32'(mode_err), 32'(e));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        armed    = 1'b0;
        reset    = 1'b1;

        step(1'b1, 3'd0, 16'hFFFF);
        lit("rst1", 32'h0, 1'b0, 1'b0);
        step(1'b1, 3'd0, 16'hFFFF);
        lit("rst2", 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b0, 3'bxxx, 16'hxxxx);
        lit("idle", 32'h0, 1'b0, 1'b0);

        step(1'b1, 3'd0, 16'h8001);
        lit("sx8001", 32'hFFFF8001, 1'b1, 1'b0);
        step(1'b1, 3'd0, 16'h7FFF);
        lit("sx7fff", 32'h00007FFF, 1'b1, 1'b0);
        step(1'b1, 3'd0, 16'h0000);
        lit("sx0000", 32'h00000000, 1'b1, 1'b0);
        step(1'b1, 3'd0, 16'hFFFF);
        lit("sxffff", 32'hFFFFFFFF, 1'b1, 1'b0);

        for (int i = 0; i < 65536; i++) begin
            in_valid = 1'b1;
            mode     = 3'd0;
            a        = 16'(i);
            @(negedge clk);
        end

        step(1'b1, 3'd1, 16'h8001);
        lit("zx16", 32'h00008001, 1'b1, 1'b0);
        step(1'b1, 3'd2, 16'h1234);
        lit("lui", 32'h12340000, 1'b1, 1'b0);
        step(1'b1, 3'd3, 16'hFFFF);
        lit("brneg", 32'hFFFFFFFC, 1'b1, 1'b0);
        step(1'b1, 3'd3, 16'h0004);
        lit("brpos", 32'h00000010, 1'b1, 1'b0);

        step(1'b1, 3'd4, 16'hAB80);
        lit("sx8", 32'hFFFFFF80, 1'b1, 1'b0);
        step(1'b1, 3'd5, 16'hAB80);
        lit("zx8", 32'h00000080, 1'b1, 1'b0);
        step(1'b1, 3'd6, 16'hF800);
        lit("sx12n", 32'hFFFFF800, 1'b1, 1'b0);
        step(1'b1, 3'd6, 16'h07FF);
        lit("sx12p", 32'h000007FF, 1'b1, 1'b0);

        step(1'b1, 3'd7, 16'h1234);
        lit("rsvd", 32'h0, 1'b1, 1'b1);
        step(1'b0, 3'bxxx, 16'hxxxx);
        lit("hold", 32'h0, 1'b0, 1'b1);
        step(1'b1, 3'd0, 16'h0001);
        lit("clrerr", 32'h00000001, 1'b1, 1'b0);

        step(1'b1, 3'd0, 16'h8000);
        lit("ms8000", 32'hFFFF8000, 1'b1, 1'b0);
        reset = 1'b1;
        step(1'b1, 3'd0, 16'h8001);
        lit("msrst", 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b1, 3'd0, 16'h8002);
        lit("ms8002", 32'hFFFF8002, 1'b1, 1'b0);

        step(1'b0, 3'd0, 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
